fp_add_issue: RTL
=================

Name: fp_add_issue

Overview:
- Request-side controller that sits directly upstream of the floating-point add/subtract datapath.
- Accepts single-precision add or subtract requests through a valid/ready handshake.
- Converts subtract to add by flipping the sign of op2, and resolves zero operands locally without using the adder.
- Issues all other requests to the adder, waits for completion, captures the result, and holds it until the consumer takes it.

Parameters:
- ADD_LAT, 3: maximum WAIT cycles before add_result is captured even if add_done is absent; legal range 1..15.
- CNT_W, 4: width of the wait counter; must satisfy 2**CNT_W > ADD_LAT.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset: synchronous, active-low, sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_sub  in  1  1 = op1 - op2; 0 = op1 + op2.
- req_op1  in  32  IEEE-754 single-precision operand A.
- req_op2  in  32  IEEE-754 single-precision operand B.
- add_serv  out  1  request strobe to the adder.
- op1  out  32  operand A driven to the adder.
- op2  out  32  effective operand B driven to the adder (sign already flipped for subtract).
- add_result  in  32  adder result.
- add_done  in  1  adder completion.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_result  out  32  final result.
- resp_bypass  out  1  result was produced without the adder.

Behaviour:
- Reset (n_rst = 0 at a clk edge):
  - State returns to IDLE.
  - req_ready = 0 for that cycle, then 1 from the next cycle in IDLE.
  - add_serv, resp_valid and resp_bypass = 0; op1, op2 and resp_result = 0; wait counter = 0.
  - Any in-flight operation is discarded, and reset overrides every other event in the same cycle.
- req_ready = 1 only in IDLE (combinational from state).
- Accept happens when req_valid & req_ready at a clk edge. On accept:
  - op1 is latched from req_op1.
  - op2 is latched from {req_op2[31] ^ req_sub, req_op2[30:0]}.
- Zero test: an operand is zero when exp[30:23] == 0. Denormals are flushed to zero.
- States:
  - IDLE: on accept, go to RESP if either operand is zero (bypass); otherwise go to ISSUE.
  - ISSUE (1 cycle): add_serv = 1; wait counter cleared; go to WAIT.
  - WAIT:
    - add_serv = 0; op1 and op2 stay stable; counter increments each cycle.
    - Exit when add_done = 1 or counter == ADD_LAT-1, whichever comes first.
    - On exit, resp_result <= add_result, resp_bypass <= 0, and state goes to RESP.
  - RESP: resp_valid = 1; resp_result and resp_bypass held stable; leave to IDLE on the cycle resp_ready = 1.
- Bypass result, using effective signs:
  - A zero, B nonzero: result = effective op2.
  - B zero, A nonzero: result = op1.
  - Both zero: result = 0x80000000 if both effective signs are 1, otherwise 0x00000000.
  - resp_bypass <= 1.
- Latency:
  - Bypass: resp_valid is high on the cycle after accept.
  - Adder path: resp_valid is high 2 + k cycles after accept, where k is the WAIT cycles used (1..ADD_LAT).
- Back-to-back operation: a new request cannot be accepted in the same cycle a response is consumed. IDLE is visited for at least 1 cycle.
- add_done outside WAIT is ignored.
- Counter: CNT_W bits, never wraps, because the exit condition occurs before it reaches 2**CNT_W - 1.

Optional Feature:
- Macro: FP_ADD_ISSUE_SPECIAL_EN.
- Defined: operands with exp == 255 are also resolved through the bypass path (resp_bypass = 1, never issued to the adder).
  - Any NaN -> 0x7FC00000.
  - +inf plus -inf (effective signs) -> 0x7FC00000.
  - inf plus finite or zero -> that inf.
  - Same-sign inf plus inf -> that inf.
  - Special-value checks take priority over the zero rule.
- Undefined: exp == 255 operands are treated as ordinary nonzero values and issued to the adder.

Test Plan:
- Adder path, add: 0x3F800000 + 0x40000000 with req_sub = 0 and add_done pulsed in the 1st WAIT cycle with add_result = 0x40400000 -> add_serv high exactly 1 cycle; resp_result = 0x40400000 and resp_bypass = 0 three cycles after accept.
- Subtract: op1 = 0x40400000, op2 = 0x3F800000, req_sub = 1 -> adder op2 port = 0xBF800000; resp_result equals whatever add_result holds on the done cycle.
- Zero bypass: 0x00000000 - 0x40A00000 -> resp_result = 0xC0A00000, resp_bypass = 1, resp_valid high 1 cycle after accept, add_serv never high. Separately, 0x80000000 + 0x80000000 -> 0x80000000.
- Timeout: add_done held 0 with ADD_LAT = 3 -> result captured at the 3rd WAIT cycle; resp_valid high 5 cycles after accept.
- Backpressure: resp_ready held 0 for 5 cycles -> resp_valid and resp_result held stable and req_ready = 0 throughout; on resp_ready = 1, return to IDLE and req_ready = 1 the following cycle.
- Reset mid-WAIT: n_rst = 0 for 1 edge -> all outputs 0; the next request completes normally; the stale add_done from the aborted operation is ignored.

Source files
------------

// File: rtl/fp_add_issue.sv
// Issue controller in front of the single-precision add/sub datapath: zero-operand bypass, adder handshake, result hold.
// Optional macro FP_ADD_ISSUE_SPECIAL_EN also resolves inf/NaN operands locally.
module fp_add_issue #(
  parameter int ADD_LAT = 3,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_sub,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic        add_serv,
  output logic [31:0] op1,
  output logic [31:0] op2,
  input  logic [31:0] add_result,
  input  logic        add_done,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_bypass
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADD_LAT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             accept, wait_exit;
  logic             a_zero, b_zero, take_bypass;
  logic [31:0]      eff_b, zero_result, byp_result;

  assign req_ready  = n_rst && (state == IDLE);
  assign add_serv   = (state == ISSUE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  assign wait_exit  = add_done || (cnt == CNT_LAST);

  // Subtract becomes add by flipping op2's sign; denormals count as zero.
  assign eff_b  = {req_op2[31] ^ req_sub, req_op2[30:0]};
  assign a_zero = (req_op1[30:23] == 8'd0);
  assign b_zero = (eff_b[30:23] == 8'd0);

  always_comb begin
    zero_result = req_op1;
    if (a_zero && b_zero)
      zero_result = (req_op1[31] && eff_b[31]) ? 32'h8000_0000 : 32'h0000_0000;
    else if (a_zero)
      zero_result = eff_b;
  end

`ifdef FP_ADD_ISSUE_SPECIAL_EN
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic a_spec, b_spec, a_nan, b_nan;

  assign a_spec = &req_op1[30:23];
  assign b_spec = &eff_b[30:23];
  assign a_nan  = a_spec && (req_op1[22:0] != 23'd0);
  assign b_nan  = b_spec && (eff_b[22:0] != 23'd0);
  assign take_bypass = a_zero || b_zero || a_spec || b_spec;

  // Special values outrank the zero rule; opposite-sign infinities give NaN.
  always_comb begin
    byp_result = zero_result;
    if (a_nan || b_nan)
      byp_result = QNAN;
    else if (a_spec && b_spec)
      byp_result = (req_op1[31] != eff_b[31]) ? QNAN : req_op1;
    else if (a_spec)
      byp_result = req_op1;
    else if (b_spec)
      byp_result = eff_b;
  end
`else
  assign take_bypass = a_zero || b_zero;
  assign byp_result  = zero_result;
`endif

  always_ff @(posedge clk) begin
    if (!n_rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = take_bypass ? RESP : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_exit) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands stay latched for the whole adder transaction; the result is held through RESP.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      op1         <= '0;
      op2         <= '0;
      resp_result <= '0;
      resp_bypass <= 1'b0;
      cnt         <= '0;
    end else begin
      if (accept) begin
        op1 <= req_op1;
        op2 <= eff_b;
        if (take_bypass) begin
          resp_result <= byp_result;
          resp_bypass <= 1'b1;
        end
      end
      if (state == ISSUE) begin
        cnt <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + CNT_W'(1);
        if (wait_exit) begin
          resp_result <= add_result;
          resp_bypass <= 1'b0;
        end
      end
    end
  end

endmodule
